// File: rtl/branch_predict_unit.sv
// IF-stage branch predictor: direct-mapped BTB with a 2-bit saturating counter per entry.
// Lookup and mispredict detection are combinational. Table and statistics update on the clock edge.
module branch_predict_unit #(
    parameter int ENTRIES = 16,
    parameter int PC_W    = 32,
    parameter int CNT_W   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] lk_pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_en,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_pred,
    input  logic [PC_W-1:0] upd_pred_target,
    output logic            mispredict,
    output logic [PC_W-1:0] redirect_pc,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    // Handshake: upd_en is a one-cycle valid strobe with no ready; EX may
    // present a resolved branch every cycle and each one is consumed at once.
    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [PC_W-1:0]  target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [TAG_W-1:0] upd_tag;
    logic             lk_hit;
    logic             upd_hit;
    logic             unused_pc_bits;

    assign lk_idx  = lk_pc[IDX_W+1:2];
    assign lk_tag  = lk_pc[PC_W-1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[PC_W-1:IDX_W+2];
    // Byte-offset bits never select an entry.
    assign unused_pc_bits = ^{lk_pc[1:0], upd_pc[1:0]};

    assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    assign pred_taken  = lk_hit && ctr_q[lk_idx][1];
    assign pred_target = pred_taken ? target_q[lk_idx] : lk_pc + PC_W'(4);

    always_comb begin
        mispredict  = 1'b0;
        redirect_pc = '0;
        if (upd_en) begin
            mispredict  = (upd_taken != upd_pred) ||
                          (upd_taken && upd_pred && (upd_target != upd_pred_target));
            redirect_pc = upd_taken ? upd_target : upd_pc + PC_W'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (upd_en) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    if (ctr_q[upd_idx] != 2'b11) ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'b01;
                    target_q[upd_idx] <= upd_target;
                end else if (ctr_q[upd_idx] != 2'b00) begin
                    ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'b01;
                end
            end else if (upd_taken) begin
                // New taken branches start weakly taken; not-taken misses never allocate.
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target;
                ctr_q[upd_idx]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (upd_en && (br_cnt_q != '1))     br_cnt_q   <= br_cnt_q + CNT_W'(1);
            if (mispredict && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
        end
    end

    assign br_cnt   = br_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule
